// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// word geometry and default sizing.
package prog_loader_pkg;

  localparam int BYTES_PER_WORD    = 4;
  localparam int MAX_WORDS_DEFAULT = 64;
  localparam int ADDR_W_DEFAULT    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_e;

  function automatic logic takes_bytes(input state_e s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

  function automatic logic is_loading(input state_e s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_WRITE) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// slave = loader side, master = stream source / memory side.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word. word_o only changes
// when the fourth byte lands, so it holds its value between memory writes.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clock,
  input  logic        rst,
  input  logic [7:0]  byte_i,
  input  logic        strobe_i,
  input  logic        clear_i,
  output logic [1:0]  byte_idx_o,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  idx_q,   idx_d;
  logic [23:0] lanes_q, lanes_d;
  logic [31:0] word_q,  word_d;
  logic        full_q,  full_d;

  // Next-state for byte lanes, index and completed word
  always_comb begin
    idx_d   = idx_q;
    lanes_d = lanes_q;
    word_d  = word_q;
    full_d  = 1'b0;
    if (clear_i) begin
      idx_d = 2'd0;
    end else if (strobe_i) begin
      case (idx_q)
        2'd0:    lanes_d[7:0]   = byte_i;
        2'd1:    lanes_d[15:8]  = byte_i;
        2'd2:    lanes_d[23:16] = byte_i;
        default: begin
          word_d = {byte_i, lanes_q};
          full_d = 1'b1;
        end
      endcase
      idx_d = (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
    end else begin
      idx_d = idx_q;
    end
  end

  // Assembler state registers
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      idx_q   <= 2'd0;
      lanes_q <= 24'h000000;
      word_q  <= 32'h0000_0000;
      full_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      word_q  <= word_d;
      full_q  <= full_d;
    end
  end

  assign byte_idx_o  = idx_q;
  assign word_o      = word_q;
  assign word_full_o = full_q;

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: length byte, then little-endian words written to
// instruction memory while the core is held. Optional checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         core_hold,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);
  localparam logic [8:0] MAX_N    = 9'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        widx_q, widx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              in_ready_q, in_ready_d;
  logic              im_we_q, im_we_d;
  logic              core_hold_q, core_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              accept_s;
  logic              asm_clear_s;
  logic              asm_strobe_s;
  logic [1:0]        byte_idx_s;
  logic [31:0]       word_s;
  logic              word_full_s;
  logic [7:0]        next_idx_s;

  assign accept_s     = bus.in_valid & in_ready_q;
  assign asm_strobe_s = accept_s & (state_q == ST_DATA);
  assign next_idx_s   = widx_q + 8'd1;

  word_assembler u_asm (
    .clock       (clock),
    .rst         (rst),
    .byte_i      (bus.in_data),
    .strobe_i    (asm_strobe_s),
    .clear_i     (asm_clear_s),
    .byte_idx_o  (byte_idx_s),
    .word_o      (word_s),
    .word_full_o (word_full_s)
  );

  // Load sequencing and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    widx_d      = widx_q;
    addr_d      = addr_q;
    asm_clear_s = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d     = ST_LEN;
          asm_clear_s = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d      = 8'h00;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN: begin
        if (!accept_s) begin
          state_d = state_q;
        end else if (bus.in_data == 8'h00) begin
          state_d = ST_DONE;
        end else if ({1'b0, bus.in_data} > MAX_N) begin
          state_d = ST_ERROR;
        end else begin
          len_d   = bus.in_data;
          widx_d  = 8'h00;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.in_data;
`endif
          if (byte_idx_s == LAST_IDX) begin
            state_d = ST_WRITE;
            addr_d  = ADDR_W'({widx_q, 2'b00});
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_WRITE: begin
        // A write cycle without a freshly completed word means the datapath lost sync
        if (!word_full_s) begin
          state_d = ST_ERROR;
        end else begin
          widx_d = next_idx_s;
          if (next_idx_s == len_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept_s) begin
          state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERROR;
        end else begin
          state_d = state_q;
        end
      end
`endif
      default: begin
        state_d = ST_ERROR;
      end
    endcase

    in_ready_d  = takes_bytes(state_d);
    busy_d      = is_loading(state_d);
    im_we_d     = (state_d == ST_WRITE);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERROR);
    core_hold_d = (state_d != ST_DONE);
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      len_q       <= 8'h00;
      widx_q      <= 8'h00;
      addr_q      <= '0;
      in_ready_q  <= 1'b0;
      im_we_q     <= 1'b0;
      core_hold_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      widx_q      <= widx_d;
      addr_q      <= addr_d;
      in_ready_q  <= in_ready_d;
      im_we_q     <= im_we_d;
      core_hold_q <= core_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = addr_q;
  assign bus.im_wdata = word_s;
  assign core_hold    = core_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a byte-list model predicts the writes and the
// final status; a negedge monitor compares every cycle, plus literal pins.
module tb_prog_loader;
  import prog_loader_pkg::*;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clock = 1'b0;
  logic rst, start;
  logic core_hold, busy, done, error;

  prog_loader_if #(.ADDR_W(8)) bus ();

  prog_loader #(.ADDR_W(8), .MAX_WORDS(64)) dut (
    .clock     (clock),
    .rst       (rst),
    .start     (start),
    .bus       (bus.slave),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  wr_t exp_q[$];
  wr_t got_log[$];
  bit  fin_direct = 1'b0;
  bit  pend_final = 1'b0;
  bit  gap_en = 1'b0;
  bit  first_wr = 1'b1;
  bit  vphase = 1'b1;
  int  last_we_cyc = 0;
  logic [7:0]  last_addr = 8'h00;
  logic [31:0] last_data = 32'h0;
  wr_t mon_w;
  logic [7:0] prog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: expected writes and final status straight from the byte list.
  task automatic build_model(input logic [7:0] p[$], output bit exp_done);
    int n;
    logic [7:0] x;
    wr_t w;
    n = int'(p[0]);
    x = 8'h00;
    fin_direct = 1'b0;
    if (n == 0) begin
      exp_done = 1'b1;
    end else if (n > 64) begin
      exp_done = 1'b0;
    end else begin
      for (int i = 0; i < n; i++) begin
        w.a = 8'(i * 4);
        w.d = {p[4*i+4], p[4*i+3], p[4*i+2], p[4*i+1]};
        x = x ^ p[4*i+1] ^ p[4*i+2] ^ p[4*i+3] ^ p[4*i+4];
        exp_q.push_back(w);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      exp_done = (p[4*n+1] == x);
`else
      exp_done = 1'b1;
      fin_direct = 1'b1;
`endif
    end
  endtask

  task automatic add_ck(inout logic [7:0] p[$]);
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < p.size(); i++) x = x ^ p[i];
    p.push_back(x);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_state", {28'h0, core_hold, done, error, busy}, 32'h9);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int n;
    for (n = 0; n < 20; n++) begin
      @(negedge clock);
      bus.in_valid = toggle ? vphase : 1'b1;
      vphase = ~vphase;
      bus.in_data = b;
      if (bus.in_valid && bus.in_ready) break;
    end
    if (n == 20) begin
      total++;
      bad++;
      $display("FAIL byte_timeout: actual=not_accepted required=accepted byte=%0h", b);
    end
  endtask

  task automatic run_load(input logic [7:0] p[$], input bit toggle, input bit gap, input string tag);
    bit exp_done;
    int n;
    got_log.delete();
    build_model(p, exp_done);
    gap_en = gap;
    first_wr = 1'b1;
    pulse_start();
    foreach (p[i]) send_byte(p[i], toggle);
    @(negedge clock);
    bus.in_valid = 1'b0;
    for (n = 0; n < 20 && !(done || error); n++) @(negedge clock);
    chk({tag, "_done"}, {31'h0, done}, {31'h0, exp_done});
    chk({tag, "_error"}, {31'h0, error}, {31'h0, !exp_done});
    chk({tag, "_hold"}, {31'h0, core_hold}, {31'h0, !exp_done});
    chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  // Per-cycle compare of outputs against the model and stream rules
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (rst !== 1'b1) begin
        last_addr = 8'h00;
        last_data = 32'h0;
        pend_final = 1'b0;
        first_wr = 1'b1;
      end else begin
        chk("hold_vs_done", {31'h0, core_hold}, {31'h0, !done});
        chk("ready_needs_busy", {31'h0, bus.in_ready & !busy}, 32'h0);
        if (pend_final) begin
          chk("done_after_last_write", {30'h0, done, core_hold}, 32'h2);
          pend_final = 1'b0;
        end
        if (bus.im_we) begin
          mon_w.a = bus.im_addr;
          mon_w.d = bus.im_wdata;
          got_log.push_back(mon_w);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: actual=%0h@%0h required=none", bus.im_wdata, bus.im_addr);
          end else begin
            mon_w = exp_q.pop_front();
            chk("wr_addr", {24'h0, bus.im_addr}, {24'h0, mon_w.a});
            chk("wr_data", bus.im_wdata, mon_w.d);
            if (exp_q.size() == 0 && fin_direct) pend_final = 1'b1;
          end
          if (gap_en && !first_wr) chk("write_gap", 32'(cyc - last_we_cyc), 32'd5);
          first_wr = 1'b0;
          last_we_cyc = cyc;
          last_addr = bus.im_addr;
          last_data = bus.im_wdata;
        end else begin
          chk("addr_hold", {24'h0, bus.im_addr}, {24'h0, last_addr});
          chk("data_hold", bus.im_wdata, last_data);
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_flags"}, {26'h0, core_hold, busy, done, error, bus.in_ready, bus.im_we}, 32'h20);
    chk({tag, "_addr"}, {24'h0, bus.im_addr}, 32'h0);
    chk({tag, "_wdata"}, bus.im_wdata, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    #2 rst = 1'b1;

    // Two-word program, stream never stalls
    prog = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    add_ck(prog);
    run_load(prog, 1'b0, 1'b1, "two_words");
    chk("pin_nwrites", 32'(got_log.size()), 32'd2);
    if (got_log.size() == 2) begin
      chk("pin_w0_addr", {24'h0, got_log[0].a}, 32'h00);
      chk("pin_w0_data", got_log[0].d, 32'h0000_0013);
      chk("pin_w1_addr", {24'h0, got_log[1].a}, 32'h04);
      chk("pin_w1_data", got_log[1].d, 32'h0010_0093);
    end

    // Same program reloaded from DONE with in_valid toggling every cycle
    run_load(prog, 1'b1, 1'b0, "toggled");
    chk("pin_tog_nwrites", 32'(got_log.size()), 32'd2);
    if (got_log.size() == 2) begin
      chk("pin_tog_w0", got_log[0].d, 32'h0000_0013);
      chk("pin_tog_w1", got_log[1].d, 32'h0010_0093);
      chk("pin_tog_a1", {24'h0, got_log[1].a}, 32'h04);
    end

    // Zero-length and oversize length bytes
    prog = '{8'h00};
    run_load(prog, 1'b0, 1'b0, "len0");
    chk("pin_len0_done", {30'h0, done, core_hold}, 32'h2);
    chk("pin_len0_nwrites", 32'(got_log.size()), 32'd0);
    prog = '{8'h41};
    run_load(prog, 1'b0, 1'b0, "len41");
    chk("pin_len41_err", {30'h0, error, core_hold}, 32'h3);
    chk("pin_len41_nwrites", 32'(got_log.size()), 32'd0);

    // Full-size program: last word lands at (MAX_WORDS-1)*4
    prog = '{8'h40};
    for (int i = 0; i < 64; i++) begin
      prog.push_back(8'(i));
      prog.push_back(8'h5A);
      prog.push_back(~8'(i));
      prog.push_back(8'hC3);
    end
    add_ck(prog);
    run_load(prog, 1'b0, 1'b1, "max");
    chk("pin_max_nwrites", 32'(got_log.size()), 32'd64);
    if (got_log.size() == 64) begin
      chk("pin_max_last_addr", {24'h0, got_log[63].a}, 32'hFC);
      chk("pin_max_last_data", got_log[63].d, 32'hC3C0_5A3F);
    end

    // Reset after two data bytes, then a fresh one-word load
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_values("midreset");
    #2 rst = 1'b1;
    prog = '{8'h01, 8'h33, 8'h00, 8'h00, 8'h00};
    add_ck(prog);
    run_load(prog, 1'b0, 1'b1, "after_reset");
    chk("pin_ar_nwrites", 32'(got_log.size()), 32'd1);
    if (got_log.size() == 1) begin
      chk("pin_ar_addr", {24'h0, got_log[0].a}, 32'h00);
      chk("pin_ar_data", got_log[0].d, 32'h0000_0033);
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    prog = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    run_load(prog, 1'b0, 1'b0, "ck_good");
    chk("pin_ck_good", {30'h0, done, core_hold}, 32'h2);
    prog = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    run_load(prog, 1'b0, 1'b0, "ck_bad");
    chk("pin_ck_bad", {30'h0, error, core_hold}, 32'h3);
`endif

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
